// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared opcodes, ALU codes and state encodings for the multi-cycle control FSM
package multicycle_control_pkg;

  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int OPW_DEF         = 6;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [3:0] ST_IF     = 4'd0;
  localparam logic [3:0] ST_DEC    = 4'd1;
  localparam logic [3:0] ST_EX     = 4'd2;
  localparam logic [3:0] ST_EX_BR  = 4'd3;
  localparam logic [3:0] ST_MEM_RD = 4'd4;
  localparam logic [3:0] ST_MEM_WR = 4'd5;
  localparam logic [3:0] ST_WB_ALU = 4'd6;
  localparam logic [3:0] ST_WB_MEM = 4'd7;

  typedef enum logic [3:0] {
    S_IF     = ST_IF,
    S_DEC    = ST_DEC,
    S_EX     = ST_EX,
    S_EX_BR  = ST_EX_BR,
    S_MEM_RD = ST_MEM_RD,
    S_MEM_WR = ST_MEM_WR,
    S_WB_ALU = ST_WB_ALU,
    S_WB_MEM = ST_WB_MEM
  } state_t;

  // One-hot instruction class; all-zero never occurs (unknown opcodes set nop)
  typedef struct packed {
    logic rtype;
    logic imm;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic nop;
  } op_class_t;

endpackage

// File: rtl/multicycle_control_opcode_decoder.sv
// rtl/multicycle_control_opcode_decoder.sv - maps the IR opcode to an instruction class and ALU operation
module multicycle_control_opcode_decoder
  import multicycle_control_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic [31:0] instr_i,
  output op_class_t   cls_o,
  output logic [3:0]  alu_func_o
);

  logic [OPW-1:0] opcode;
  logic           unused_instr;

  assign opcode       = instr_i[31 -: OPW];
  assign unused_instr = ^instr_i[31-OPW:4];

  // Class flags and ALU code; anything unrecognised is a NOP
  always_comb begin
    cls_o      = '0;
    alu_func_o = ALU_ADD;
    case (opcode)
      OPW'(OP_RTYPE): begin
        cls_o.rtype = 1'b1;
        alu_func_o  = instr_i[3:0];
      end
      OPW'(OP_ADDI): begin
        cls_o.imm  = 1'b1;
        alu_func_o = ALU_ADD;
      end
      OPW'(OP_ANDI): begin
        cls_o.imm  = 1'b1;
        alu_func_o = ALU_AND;
      end
      OPW'(OP_ORI): begin
        cls_o.imm  = 1'b1;
        alu_func_o = ALU_OR;
      end
      OPW'(OP_LW): begin
        cls_o.lw   = 1'b1;
        alu_func_o = ALU_ADD;
      end
      OPW'(OP_SW): begin
        cls_o.sw   = 1'b1;
        alu_func_o = ALU_ADD;
      end
      OPW'(OP_BEQ): begin
        cls_o.beq  = 1'b1;
        alu_func_o = ALU_SUB;
      end
      OPW'(OP_BNE): begin
        cls_o.bne  = 1'b1;
        alu_func_o = ALU_SUB;
      end
      default: cls_o.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle datapath control FSM with memory handshake and timeout guard
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int OPW         = OPW_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] Instr,
  input  logic        ALU_zero,
  input  logic        MEM_ACK,
  output logic        IR_WE,
  output logic        AB_WE,
  output logic        ALUOUT_WE,
  output logic        MDR_WE,
  output logic        RF_WE,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        PC_sel,
  output logic        PC_LdEn,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic        MEM_ERR,
  output logic [3:0]  State
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            err_q, err_d;

  op_class_t       cls;
  logic [3:0]      dec_func;
  logic            in_mem;
  logic            timeout;

  logic ir_we, ab_we, aluout_we, mdr_we, rf_we;
  logic rf_wrdata_sel, rf_b_sel, alu_bin_sel;
  logic [3:0] alu_func;
  logic pc_sel, pc_lden, mem_req, mem_we;

  multicycle_control_opcode_decoder #(
    .OPW(OPW)
  ) u_dec (
    .instr_i    (Instr),
    .cls_o      (cls),
    .alu_func_o (dec_func)
  );

  assign in_mem  = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // Last permitted wait cycle; an ACK here still wins
  assign timeout = in_mem && !MEM_ACK && (wait_q == CW'(MEM_TIMEOUT - 1));

  // State register, memory wait counter and sticky timeout flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IF;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Next state and control decode; Mealy terms only in EX_BR and MEM_*
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    err_d         = err_q | timeout;
    ir_we         = 1'b0;
    ab_we         = 1'b0;
    aluout_we     = 1'b0;
    mdr_we        = 1'b0;
    rf_we         = 1'b0;
    rf_wrdata_sel = 1'b0;
    rf_b_sel      = 1'b0;
    alu_bin_sel   = 1'b0;
    alu_func      = ALU_ADD;
    pc_sel        = 1'b0;
    pc_lden       = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    case (state_q)
      S_IF: begin
        ir_we   = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        ab_we    = 1'b1;
        rf_b_sel = cls.sw | cls.beq | cls.bne;
        if (cls.nop) begin
          pc_lden = 1'b1;
          state_d = S_IF;
        end else if (cls.beq || cls.bne) begin
          state_d = S_EX_BR;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        aluout_we   = 1'b1;
        alu_bin_sel = cls.imm | cls.lw | cls.sw;
        alu_func    = dec_func;
        if (cls.lw)      state_d = S_MEM_RD;
        else if (cls.sw) state_d = S_MEM_WR;
        else             state_d = S_WB_ALU;
      end
      S_EX_BR: begin
        pc_lden  = 1'b1;
        alu_func = dec_func;
        pc_sel   = cls.beq ? ALU_zero : ~ALU_zero;
        state_d  = S_IF;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        mdr_we  = MEM_ACK;
        if (MEM_ACK) begin
          state_d = S_WB_MEM;
        end else if (timeout) begin
          pc_lden = 1'b1;
          state_d = S_IF;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (MEM_ACK || timeout) begin
          pc_lden = 1'b1;
          state_d = S_IF;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB_ALU: begin
        rf_we   = 1'b1;
        pc_lden = 1'b1;
        state_d = S_IF;
      end
      S_WB_MEM: begin
        rf_we         = 1'b1;
        rf_wrdata_sel = 1'b1;
        pc_lden       = 1'b1;
        state_d       = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Hold every control low while reset is asserted, including IF's IR_WE
  assign IR_WE         = ir_we & RST_N;
  assign AB_WE         = ab_we & RST_N;
  assign ALUOUT_WE     = aluout_we & RST_N;
  assign MDR_WE        = mdr_we & RST_N;
  assign RF_WE         = rf_we & RST_N;
  assign RF_WrData_sel = rf_wrdata_sel & RST_N;
  assign RF_B_sel      = rf_b_sel & RST_N;
  assign ALU_Bin_sel   = alu_bin_sel & RST_N;
  assign ALU_func      = RST_N ? alu_func : 4'd0;
  assign PC_sel        = pc_sel & RST_N;
  assign PC_LdEn       = pc_lden & RST_N;
  assign MEM_REQ       = mem_req & RST_N;
  assign MEM_WE        = mem_we & RST_N;
  assign MEM_ERR       = err_q;
  assign State         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] Instr = '0;
  logic        ALU_zero = 1'b0;
  logic        MEM_ACK = 1'b0;
  logic        IR_WE, AB_WE, ALUOUT_WE, MDR_WE, RF_WE, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        PC_sel, PC_LdEn, MEM_REQ, MEM_WE, MEM_ERR;
  logic [3:0]  State;

  multicycle_control #(.MEM_TIMEOUT(TO), .OPW(6)) dut (
    .CLK(CLK), .RST_N(RST_N), .Instr(Instr), .ALU_zero(ALU_zero), .MEM_ACK(MEM_ACK),
    .IR_WE(IR_WE), .AB_WE(AB_WE), .ALUOUT_WE(ALUOUT_WE), .MDR_WE(MDR_WE), .RF_WE(RF_WE),
    .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .MEM_REQ(MEM_REQ),
    .MEM_WE(MEM_WE), .MEM_ERR(MEM_ERR), .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic ir, ab, ao, mdr, rf, wsel, bsel, bin;
    logic [3:0] func;
    logic pcsel, pcld, req, mwe, err;
    logic [3:0] st;
    logic ack, zero;
  } cyc_t;

  typedef enum int {C_RTYPE, C_ADDI, C_ANDI, C_ORI, C_LW, C_SW, C_BEQ, C_BNE, C_NOP} cls_t;

  typedef struct {
    cls_t        cls;
    logic [31:0] instr;
    int          w;
    logic        z;
    int          exp_cyc;
    logic        exp_err;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  logic cur_err = 1'b0;
  cyc_t trace[$];
  vec_t vecs[17];

  function automatic logic [20:0] dut_vec();
    return {IR_WE, AB_WE, ALUOUT_WE, MDR_WE, RF_WE, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
            ALU_func, PC_sel, PC_LdEn, MEM_REQ, MEM_WE, MEM_ERR, State};
  endfunction

  function automatic logic [20:0] exp_vec(input cyc_t e);
    return {e.ir, e.ab, e.ao, e.mdr, e.rf, e.wsel, e.bsel, e.bin,
            e.func, e.pcsel, e.pcld, e.req, e.mwe, e.err, e.st};
  endfunction

  function automatic logic [5:0] op_of(input cls_t c);
    case (c)
      C_RTYPE: return 6'b100000;
      C_ADDI:  return 6'b110000;
      C_ANDI:  return 6'b110010;
      C_ORI:   return 6'b110011;
      C_LW:    return 6'b001111;
      C_SW:    return 6'b011111;
      C_BEQ:   return 6'b010000;
      C_BNE:   return 6'b010001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic bit known_op(input logic [5:0] op);
    for (int k = 0; k < 8; k++)
      if (op == op_of(cls_t'(k))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] func_of(input cls_t c, input logic [31:0] ins);
    logic [3:0] f;
    case (c)
      C_RTYPE:      f = ins[3:0];
      C_ANDI:       f = 4'b0010;
      C_ORI:        f = 4'b0011;
      C_BEQ, C_BNE: f = 4'b0001;
      default:      f = 4'b0000;
    endcase
    return f;
  endfunction

  function automatic cyc_t blank(input logic [3:0] st);
    cyc_t e;
    e = '{default: '0};
    e.st   = st;
    e.err  = cur_err;
    e.ack  = 1'($urandom & 1);
    e.zero = 1'($urandom & 1);
    return e;
  endfunction

  // Reference timeline: one entry per cycle the instruction should occupy
  task automatic build(input cls_t c, input logic [31:0] ins, input int w, input logic z);
    cyc_t e;
    bit   br, mem;
    br  = (c == C_BEQ) || (c == C_BNE);
    mem = (c == C_LW) || (c == C_SW);
    trace.delete();
    e = blank(ST_IF); e.ir = 1'b1; trace.push_back(e);
    e = blank(ST_DEC); e.ab = 1'b1; e.bsel = (c == C_SW) || br; e.pcld = (c == C_NOP);
    trace.push_back(e);
    if (c == C_NOP) return;
    if (br) begin
      e = blank(ST_EX_BR); e.zero = z; e.func = 4'b0001; e.pcld = 1'b1;
      e.pcsel = (c == C_BEQ) ? z : !z;
      trace.push_back(e);
      return;
    end
    e = blank(ST_EX); e.ao = 1'b1; e.bin = (c != C_RTYPE); e.func = func_of(c, ins);
    trace.push_back(e);
    if (!mem) begin
      e = blank(ST_WB_ALU); e.rf = 1'b1; e.pcld = 1'b1; trace.push_back(e);
      return;
    end
    for (int k = 0; k < TO; k++) begin
      e = blank(c == C_LW ? ST_MEM_RD : ST_MEM_WR);
      e.req = 1'b1; e.mwe = (c == C_SW); e.ack = (k == w);
      if (k == w) begin
        if (c == C_LW) e.mdr = 1'b1; else e.pcld = 1'b1;
        trace.push_back(e);
        break;
      end
      if (k == TO - 1) begin
        e.pcld = 1'b1;
        trace.push_back(e);
        cur_err = 1'b1;
        return;
      end
      trace.push_back(e);
    end
    if (c == C_LW) begin
      e = blank(ST_WB_MEM); e.rf = 1'b1; e.wsel = 1'b1; e.pcld = 1'b1; trace.push_back(e);
    end
  endtask

  task automatic check(input string nm, input int i, input logic [20:0] got, input logic [20:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b required %b", nm, i, got, want);
    end
  endtask

  // Entered at posedge+1; leaves at posedge+1 of the following instruction
  task automatic apply(input string nm, input int n, output int dut_len);
    dut_len = 1;
    for (int i = 0; i < n; i++) begin
      MEM_ACK  = trace[i].ack;
      ALU_zero = trace[i].zero;
      @(negedge CLK);
      check(nm, i, dut_vec(), exp_vec(trace[i]));
      if (i > 0 && State != ST_IF) dut_len++;
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    len;
    cls_t  c;
    logic [5:0] op;
    logic [31:0] ins;

    vecs[0]  = '{C_RTYPE, 32'h8000_0004, 0,  1'b0, 4, 1'b0};
    vecs[1]  = '{C_ADDI,  32'hC012_3456, 0,  1'b0, 4, 1'b0};
    vecs[2]  = '{C_ANDI,  32'hC800_FFFF, 0,  1'b1, 4, 1'b0};
    vecs[3]  = '{C_ORI,   32'hCC00_0007, 0,  1'b0, 4, 1'b0};
    vecs[4]  = '{C_LW,    32'h3C21_0010, 2,  1'b0, 7, 1'b0};
    vecs[5]  = '{C_LW,    32'h3C21_0020, 0,  1'b1, 5, 1'b0};
    vecs[6]  = '{C_SW,    32'h7C21_0030, 0,  1'b0, 4, 1'b0};
    vecs[7]  = '{C_BEQ,   32'h4000_0001, 0,  1'b1, 3, 1'b0};
    vecs[8]  = '{C_BNE,   32'h4400_0002, 0,  1'b1, 3, 1'b0};
    vecs[9]  = '{C_BEQ,   32'h4000_0003, 0,  1'b0, 3, 1'b0};
    vecs[10] = '{C_BNE,   32'h4400_0004, 0,  1'b0, 3, 1'b0};
    vecs[11] = '{C_NOP,   32'h0000_0000, 0,  1'b0, 2, 1'b0};
    vecs[12] = '{C_NOP,   32'hFC00_000F, 0,  1'b1, 2, 1'b0};
    vecs[13] = '{C_SW,    32'h7C00_0040, 3,  1'b0, 7, 1'b0};
    vecs[14] = '{C_LW,    32'h3C00_0050, 3,  1'b0, 8, 1'b0};
    vecs[15] = '{C_SW,    32'h7C00_0060, 99, 1'b0, 7, 1'b1};
    vecs[16] = '{C_RTYPE, 32'h8000_000A, 0,  1'b0, 4, 1'b1};

    // Reset held: every output low whatever MEM_ACK does
    for (int i = 0; i < 3; i++) begin
      MEM_ACK = 1'($urandom & 1);
      @(negedge CLK);
      check("reset_hold", i, dut_vec(), 21'd0);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    for (int v = 0; v < 17; v++) begin
      Instr = vecs[v].instr;
      build(vecs[v].cls, vecs[v].instr, vecs[v].w, vecs[v].z);
      apply($sformatf("vec%0d", v), trace.size(), len);
      check($sformatf("vec%0d_cycles", v), 0, 21'(len), 21'(vecs[v].exp_cyc));
      check($sformatf("vec%0d_err", v), 0, 21'(MEM_ERR), 21'(vecs[v].exp_err));
    end

    // Asynchronous reset in the middle of a load's memory wait
    Instr = 32'h3C00_0070;
    build(C_LW, Instr, 99, 1'b0);
    apply("lw_abort", 4, len);
    MEM_ACK = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst", 0, dut_vec(), 21'd0);
    cur_err = 1'b0;
    @(posedge CLK);
    #1;
    check("async_rst_hold", 1, dut_vec(), 21'd0);
    RST_N = 1'b1;

    // Random instruction stream against the timeline model
    for (int n = 0; n < 150; n++) begin
      c = cls_t'($urandom_range(0, 8));
      if (c == C_NOP) begin
        do op = 6'($urandom); while (known_op(op));
      end else begin
        op = op_of(c);
      end
      ins = {op, 26'($urandom)};
      Instr = ins;
      build(c, ins, $urandom_range(0, 5), 1'($urandom & 1));
      apply($sformatf("rnd%0d", n), trace.size(), len);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
